// File: rtl/tmu_readout.sv
// tmu_readout: captures a PID sample and a CORDIC magnitude after a settle
// delay, tags each with a 6-bit sequence number, and queues both words in a
// show-ahead output FIFO with a sticky overflow flag.
// Optional feature macro: TMU_READOUT_SIGN_EXT_EN (sign-extend pid_data into
// the 24-bit payload; zero-extension when undefined).
module tmu_readout #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] pid_data,
  input  logic [11:0] cordic_data,
  input  logic        sample_req,
  input  logic        clear,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        overflow,
  output logic [4:0]  fifo_level
);

  localparam int          AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DEPTH_L     = 5'(FIFO_DEPTH);
  localparam logic [3:0]  SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAP_PID = 2'd2,
    ST_CAP_COR = 2'd3
  } state_t;

  // Widen the 17-bit PID sample to the 24-bit payload field.
  function automatic logic [23:0] payload24(input logic [16:0] d);
`ifdef TMU_READOUT_SIGN_EXT_EN
    payload24 = {{7{d[16]}}, d};
`else
    payload24 = {7'd0, d};
`endif
  endfunction

  state_t          state_r, state_n;
  logic [5:0]      seq_r, seq_n;
  logic [3:0]      wait_cnt_r, wait_cnt_n;
  logic            busy_r;
  logic            push_s;
  logic [31:0]     push_word_s;

  logic [31:0]     mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [4:0]      level_r, level_n;
  logic            valid_r;
  logic            overflow_r;
  logic            pop_s, full_s, wr_en_s, ovf_evt_s;

  // Sequencer next-state logic and capture word formation.
  always_comb begin
    state_n     = state_r;
    seq_n       = seq_r;
    wait_cnt_n  = wait_cnt_r;
    push_s      = 1'b0;
    push_word_s = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (sample_req) begin
          seq_n      = seq_r + 6'd1;
          wait_cnt_n = 4'd0;
          if (SETTLE == 0) begin
            state_n = ST_CAP_PID;
          end else begin
            state_n = ST_WAIT;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == SETTLE_LAST) begin
          state_n    = ST_CAP_PID;
          wait_cnt_n = 4'd0;
        end else begin
          wait_cnt_n = wait_cnt_r + 4'd1;
        end
      end
      ST_CAP_PID: begin
        push_s      = 1'b1;
        push_word_s = {2'b01, seq_r, payload24(pid_data)};
        state_n     = ST_CAP_COR;
      end
      ST_CAP_COR: begin
        push_s      = 1'b1;
        push_word_s = {2'b10, seq_r, 12'h000, cordic_data};
        state_n     = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, sequence number, settle counter and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      seq_r      <= 6'd0;
      wait_cnt_r <= 4'd0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      seq_r      <= seq_n;
      wait_cnt_r <= wait_cnt_n;
      busy_r     <= (state_n != ST_IDLE);
    end
  end

  // FIFO handshake: a pop frees the full slot so a same-edge push still lands.
  always_comb begin
    pop_s     = valid_r & out_ready;
    full_s    = (level_r == DEPTH_L);
    wr_en_s   = push_s & (~full_s | pop_s);
    ovf_evt_s = push_s & full_s & ~pop_s;
    case ({wr_en_s, pop_s})
      2'b10:   level_n = level_r + 5'd1;
      2'b01:   level_n = level_r - 5'd1;
      default: level_n = level_r;
    endcase
  end

  // FIFO pointers, occupancy count, valid flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= 5'd0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_n;
      valid_r <= (level_n != 5'd0);
      if (ovf_evt_s) begin
        overflow_r <= 1'b1;
      end else if (clear) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_word_s;
    end
  end

  assign out_data   = valid_r ? mem_r[rd_ptr_r] : 32'd0;
  assign out_valid  = valid_r;
  assign busy       = busy_r;
  assign overflow   = overflow_r;
  assign fifo_level = level_r;

endmodule

// File: tb/tb_tmu_readout.sv
// Scoreboard bench for tmu_readout (FIFO_DEPTH=4, SETTLE=3, zero-extension).
module tb_tmu_readout;

  logic        clk;
  logic        rst;
  logic [16:0] pid_data;
  logic [11:0] cordic_data;
  logic        sample_req;
  logic        clear;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        overflow;
  logic [4:0]  fifo_level;

  int checks;
  int failures;
  logic [31:0] exp_q [$];

  tmu_readout #(.FIFO_DEPTH(4), .SETTLE(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .pid_data    (pid_data),
    .cordic_data (cordic_data),
    .sample_req  (sample_req),
    .clear       (clear),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request; both words are expected (seq s) unless drop is set.
  task automatic request(input logic [16:0] pid, input logic [11:0] cor,
                         input logic [5:0] s, input logic [23:0] pay, input bit drop);
    pid_data    = pid;
    cordic_data = cor;
    if (!drop) begin
      exp_q.push_back({2'b01, s, pay});
      exp_q.push_back({2'b10, s, 12'h000, cor});
    end
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    repeat (5) tick();
  endtask

  // Monitor: every accepted head word must match the next expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%h required=none", out_data);
      end else begin
        chk("scoreboard_word", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; pid_data = 17'd0; cordic_data = 12'd0;
    sample_req = 1'b0; clear = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_busy",     32'(busy),       32'd0);
    chk("rst_valid",    32'(out_valid),  32'd0);
    chk("rst_level",    32'(fifo_level), 32'd0);
    chk("rst_overflow", 32'(overflow),   32'd0);
    chk("rst_out_data", out_data,        32'd0);
    rst = 1'b0;

    // Basic capture timing, with an ignored request while busy.
    out_ready = 1'b1; pid_data = 17'h00123; cordic_data = 12'hABC;
    exp_q.push_back(32'h41000123);
    exp_q.push_back(32'h81000ABC);
    sample_req = 1'b1;
    tick();                                   // accepting edge
    sample_req = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    tick();                                   // edge 1
    sample_req = 1'b1;
    tick();                                   // edge 2: ignored
    sample_req = 1'b0;
    tick();                                   // edge 3
    chk("no_word_before_e4", 32'(out_valid), 32'd0);
    tick();                                   // edge 4
    chk("pid_word_e4",  out_data,        32'h41000123);
    chk("busy_e4",      32'(busy),       32'd1);
    tick();                                   // edge 5
    chk("cor_word_e5",  out_data,        32'h81000ABC);
    chk("busy_falls_e5", 32'(busy),      32'd0);
    chk("level1_pushpop", 32'(fifo_level), 32'd1);
    tick();
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Overflow: three requests into a depth-4 FIFO with no consumer.
    out_ready = 1'b0;
    request(17'h10000, 12'h123, 6'd2, 24'h010000, 1'b0);
    request(17'h1FFFF, 12'hFFF, 6'd3, 24'h01FFFF, 1'b0);
    chk("full_level",    32'(fifo_level), 32'd4);
    chk("full_no_ovf",   32'(overflow),   32'd0);
    request(17'h00000, 12'h000, 6'd4, 24'h000000, 1'b1);
    chk("ovf_level",     32'(fifo_level), 32'd4);
    chk("ovf_set",       32'(overflow),   32'd1);
    chk("zero_ext_head", out_data,        32'h42010000);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_ovf",     32'(overflow),   32'd0);

    // Full FIFO: pop during the PID push, then COR dropped with clear on same edge.
    pid_data = 17'h00555; cordic_data = 12'h0AA;
    exp_q.push_back(32'h45000555);
    sample_req = 1'b1; tick(); sample_req = 1'b0;
    tick(); tick(); tick();
    out_ready = 1'b1;
    tick();                                   // edge 4: push + pop while full
    out_ready = 1'b0; clear = 1'b1;
    chk("full_pushpop_level", 32'(fifo_level), 32'd4);
    chk("full_pushpop_ovf",   32'(overflow),   32'd0);
    tick();                                   // edge 5: drop + clear
    clear = 1'b0;
    chk("ovf_beats_clear", 32'(overflow),   32'd1);
    chk("drop_level",      32'(fifo_level), 32'd4);
    chk("head_after_drop", out_data,        32'h82000123);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("empty_level",    32'(fifo_level), 32'd0);
    chk("empty_out_data", out_data,        32'd0);
    clear = 1'b1; tick(); clear = 1'b0;

    // Sequence wrap: requests 6..64, the 64th carries seq 0.
    for (int r = 6; r <= 64; r++) begin
      logic [5:0] s;
      s = 6'(r % 64);
      pid_data = 17'd0; cordic_data = 12'd0;
      exp_q.push_back({2'b01, s, 24'h000000});
      exp_q.push_back({2'b10, s, 24'h000000});
      sample_req = 1'b1; tick(); sample_req = 1'b0;
      repeat (3) tick();
      tick();
      if (r == 64) chk("seq_wrap_word", out_data, 32'h40000000);
      tick();
    end

    // Reset during WAIT aborts the capture; next request restarts at seq 1.
    sample_req = 1'b1; tick(); sample_req = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_busy",  32'(busy),       32'd0);
    chk("midrst_valid", 32'(out_valid),  32'd0);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    request(17'h00077, 12'h123, 6'd1, 24'h000077, 1'b0);
    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
